// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin stream arbiter.
//   arb_state_e   : controller state (IDLE = no packet open, LOCKED = packet
//                   owned by one requester until its last beat).
//   calc_id_width : width of a requester index, never less than one bit.
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Smallest w >= 1 with 2**w >= num_req, for num_req in 1..16.
    function automatic int calc_id_width(input int num_req);
        int w;
        w = 1;
        for (int i = 1; i < 5; i++) begin
            if (int'(32'd1 << i) < num_req) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_out_stage.sv
// -----------------------------------------------------------------------------
// arb_out_stage
// Single-entry elastic register. Accepts a new word whenever it is empty or
// the downstream side is consuming the current word, so it sustains one word
// per cycle. Contents only change on an accepted input word.
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake and payload
// -----------------------------------------------------------------------------
module arb_out_stage #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    // in_ready_o never depends on in_valid_i, so no combinational loop upstream.
    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Occupancy flag and payload register; payload loads only on a transfer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= {Width{1'b0}};
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
// Packet-aware round-robin arbiter merging NumReq valid/ready streams into one.
// A multi-beat packet locks the grant to its owner until the beat with last
// set; single-beat packets and packet ends advance the round-robin pointer.
// Output beats pass through a one-entry register stage (latency 1 cycle).
//   clk_i, reset_i         : clock, asynchronous active-high reset
//   data_i/valid_i/last_i  : per-requester payload, beat valid, end-of-packet
//   ready_o                : per-requester beat accept (at most one bit high)
//   valid_o/data_o/last_o  : merged output beat
//   id_o                   : index of the requester that sourced the beat
//   ready_i                : downstream accept
// -----------------------------------------------------------------------------
module rr_stream_arbiter
    import arb_pkg::*;
#(
    parameter  int NumReq    = 4,
    parameter  int DataWidth = 8,
    localparam int IdWidth   = calc_id_width(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [NumReq-1:0][DataWidth-1:0] data_i,
    input  logic [NumReq-1:0]                valid_i,
    input  logic [NumReq-1:0]                last_i,
    output logic [NumReq-1:0]                ready_o,
    output logic                             valid_o,
    output logic [DataWidth-1:0]             data_o,
    output logic                             last_o,
    output logic [IdWidth-1:0]               id_o,
    input  logic                             ready_i
);

    localparam int StageWidth = DataWidth + 1 + IdWidth;

    arb_state_e             state_q;
    logic [IdWidth-1:0]     ptr_q;
    logic [IdWidth-1:0]     owner_q;

    logic [NumReq-1:0]      hi_req_s;
    logic [IdWidth-1:0]     hi_idx_s;
    logic [IdWidth-1:0]     lo_idx_s;
    logic [IdWidth-1:0]     grant_s;
    logic                   grant_en_s;
    logic                   stage_ready_s;
    logic                   xfer_s;
    logic [DataWidth-1:0]   sel_data_s;
    logic                   sel_last_s;
    logic [StageWidth-1:0]  stage_in_s;
    logic [StageWidth-1:0]  stage_out_s;

    function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] idx);
        return (idx == IdWidth'(NumReq - 1)) ? {IdWidth{1'b0}} : idx + 1'b1;
    endfunction

    // Round-robin search: the lowest valid index at or above ptr_q wins,
    // otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_req_s = {NumReq{1'b0}};
        hi_idx_s = {IdWidth{1'b0}};
        lo_idx_s = {IdWidth{1'b0}};
        for (int i = NumReq - 1; i >= 0; i--) begin
            hi_req_s[i] = valid_i[i] & (IdWidth'(i) >= ptr_q);
            lo_idx_s    = valid_i[i]  ? IdWidth'(i) : lo_idx_s;
            hi_idx_s    = hi_req_s[i] ? IdWidth'(i) : hi_idx_s;
        end
    end

    // Grant selection: an open packet holds the grant on its owner even while
    // the owner has no beat ready, so no other requester can slip in.
    always_comb begin
        if (state_q == LOCKED) begin
            grant_s    = owner_q;
            grant_en_s = 1'b1;
        end else begin
            grant_s    = (|hi_req_s) ? hi_idx_s : lo_idx_s;
            grant_en_s = |valid_i;
        end
    end

    // One-hot ready toward the granted requester and payload mux.
    always_comb begin
        ready_o    = {NumReq{1'b0}};
        sel_data_s = {DataWidth{1'b0}};
        sel_last_s = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            ready_o[i] = grant_en_s & stage_ready_s & ~reset_i & (grant_s == IdWidth'(i));
            sel_data_s = (grant_s == IdWidth'(i)) ? data_i[i] : sel_data_s;
            sel_last_s = (grant_s == IdWidth'(i)) ? last_i[i] : sel_last_s;
        end
        xfer_s = |(ready_o & valid_i);
    end

    // Packet lock controller and round-robin pointer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= {IdWidth{1'b0}};
            owner_q <= {IdWidth{1'b0}};
        end else if (xfer_s) begin
            case (state_q)
                IDLE: begin
                    if (sel_last_s) begin
                        ptr_q <= wrap_inc(grant_s);
                    end else begin
                        state_q <= LOCKED;
                        owner_q <= grant_s;
                    end
                end
                LOCKED: begin
                    if (sel_last_s) begin
                        state_q <= IDLE;
                        ptr_q   <= wrap_inc(owner_q);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stage_in_s = {sel_data_s, sel_last_s, grant_s};

    arb_out_stage #(
        .Width (StageWidth)
    ) u_out_stage (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .in_valid_i  (xfer_s),
        .in_ready_o  (stage_ready_s),
        .in_data_i   (stage_in_s),
        .out_valid_o (valid_o),
        .out_data_o  (stage_out_s),
        .out_ready_i (ready_i)
    );

    assign {data_o, last_o, id_o} = stage_out_s;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_arbiter
// Self-checking bench for rr_stream_arbiter (NumReq=4, DataWidth=8). A
// behavioural model of the arbiter predicts ready_o every cycle and pushes
// each predicted accepted beat to a scoreboard queue; beats leaving the DUT
// are popped and compared. Scenario tasks add their own targeted checks.
// -----------------------------------------------------------------------------
module tb_rr_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic                clk;
    logic                rst;
    logic [N-1:0][DW-1:0] data_s;
    logic [N-1:0]        valid_s;
    logic [N-1:0]        last_s;
    logic [N-1:0]        ready_o;
    logic                ready_s;
    logic                valid_o;
    logic [DW-1:0]       data_o;
    logic                last_o;
    logic [1:0]          id_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_locked;
    int m_ptr;
    int m_owner;
    bit m_full;
    bit m_xfer;
    int m_xfer_id;
    bit m_xfer_last;

    logic [10:0] sb[$];   // expected beats {id, data, last}
    logic [10:0] obs[$];  // beats seen leaving the DUT

    rr_stream_arbiter #(.NumReq(N), .DataWidth(DW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .data_i  (data_s),
        .valid_i (valid_s),
        .last_i  (last_s),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .last_o  (last_o),
        .id_o    (id_o),
        .ready_i (ready_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_owner  = 0;
        m_full   = 1'b0;
        m_xfer   = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: predict/compare at negedge, advance model at posedge.
    task automatic step();
        logic [3:0]  exp_ready;
        logic [10:0] beat;
        logic [10:0] e;
        int  g;
        bit  ge;
        bit  out_x;
        bit  xfer;
        @(negedge clk);
        g  = m_owner;
        ge = 1'b0;
        if (m_locked) begin
            ge = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (!ge && valid_s[idx]) begin
                    g  = idx;
                    ge = 1'b1;
                end
            end
        end
        exp_ready = (ge && (!m_full || ready_s) && !rst) ? (4'b0001 << g) : 4'b0000;
        n_checks++;
        if (ready_o !== exp_ready)
            $display("FAIL ready_o: got %b expected %b at %0t", ready_o, exp_ready, $time);
        if (ready_o !== exp_ready) n_errors++;
        n_checks++;
        if (valid_o !== m_full) begin
            n_errors++;
            $display("FAIL valid_o: got %b expected %b at %0t", valid_o, m_full, $time);
        end
        out_x = m_full && ready_s;
        if (valid_o === 1'b1 && ready_s) obs.push_back({id_o, data_o, last_o});
        if (out_x) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard: DUT beat %h with nothing expected at %0t", {id_o, data_o, last_o}, $time);
            end else begin
                e = sb.pop_front();
                if ({id_o, data_o, last_o} !== e) begin
                    n_errors++;
                    $display("FAIL beat: got id=%0d data=%h last=%b expected id=%0d data=%h last=%b at %0t",
                             id_o, data_o, last_o, e[10:9], e[8:1], e[0], $time);
                end
            end
        end
        xfer        = !rst && ge && exp_ready[g] && valid_s[g];
        beat        = {2'(g), data_s[g], last_s[g]};
        m_xfer      = xfer;
        m_xfer_id   = g;
        m_xfer_last = last_s[g];
        @(posedge clk);
        if (!rst) begin
            if (xfer) begin
                sb.push_back(beat);
                if (!m_locked) begin
                    if (beat[0]) m_ptr = (g + 1) % N;
                    else begin
                        m_locked = 1'b1;
                        m_owner  = g;
                    end
                end else if (beat[0]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_owner + 1) % N;
                end
            end
            m_full = xfer ? 1'b1 : (out_x ? 1'b0 : m_full);
        end
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        valid_s = 4'b0000;
        last_s  = 4'b0000;
        data_s  = '0;
        ready_s = 1'b1;
        model_reset();
        repeat (2) step();
        rst = 1'b0;
        obs.delete();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_s = 4'b1111;
        last_s  = 4'b1111;
        ready_s = 1'b1;
        data_s  = '0;
        model_reset();
        #2;
        n_checks += 5;
        if (ready_o !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b expected 0000", ready_o); end
        if (valid_o !== 1'b0)    begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        if (data_o !== 8'h00)    begin n_errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        if (last_o !== 1'b0)     begin n_errors++; $display("FAIL reset_last: got %b expected 0", last_o); end
        if (id_o !== 2'd0)       begin n_errors++; $display("FAIL reset_id: got %0d expected 0", id_o); end
        repeat (2) step();
        rst     = 1'b0;
        valid_s = 4'b0000;
        step();
    endtask

    task automatic test_single_beat();
        logic [10:0] exp_l [0:4];
        apply_reset();
        for (int i = 0; i < N; i++) data_s[i] = 8'hA0 + 8'(i);
        valid_s = 4'b1111;
        last_s  = 4'b1111;
        repeat (6) step();
        valid_s = 4'b0000;
        repeat (2) step();
        exp_l = '{{2'd0, 8'hA0, 1'b1}, {2'd1, 8'hA1, 1'b1}, {2'd2, 8'hA2, 1'b1},
                  {2'd3, 8'hA3, 1'b1}, {2'd0, 8'hA0, 1'b1}};
        n_checks++;
        if (obs.size() < 5) begin
            n_errors++;
            $display("FAIL single_beat_count: got %0d beats expected at least 5", obs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (obs[i] !== exp_l[i]) begin
                    n_errors++;
                    $display("FAIL single_beat[%0d]: got %h expected %h", i, obs[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_locked_packet();
        logic [10:0] exp_l [0:3];
        apply_reset();
        valid_s = 4'b0110;
        data_s[1] = 8'h11; last_s[1] = 1'b0;
        data_s[2] = 8'h22; last_s[2] = 1'b1;
        step();
        data_s[1] = 8'h12;
        step();
        data_s[1] = 8'h13; last_s[1] = 1'b1;
        step();
        valid_s[1] = 1'b0;
        step();
        valid_s[2] = 1'b0;
        repeat (2) step();
        exp_l = '{{2'd1, 8'h11, 1'b0}, {2'd1, 8'h12, 1'b0}, {2'd1, 8'h13, 1'b1}, {2'd2, 8'h22, 1'b1}};
        n_checks++;
        if (obs.size() != 4) begin
            n_errors++;
            $display("FAIL locked_count: got %0d beats expected 4", obs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs[i] !== exp_l[i]) begin
                    n_errors++;
                    $display("FAIL locked[%0d]: got %h expected %h", i, obs[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_owner_stall();
        logic [10:0] exp_l [0:2];
        apply_reset();
        valid_s = 4'b1010;
        data_s[1] = 8'h31; last_s[1] = 1'b0;
        data_s[3] = 8'h33; last_s[3] = 1'b1;
        step();
        valid_s[1] = 1'b0;
        repeat (2) begin
            step();
            n_checks++;
            if (ready_o !== 4'b0010) begin
                n_errors++;
                $display("FAIL stall_ready: got %b expected 0010", ready_o);
            end
        end
        valid_s[1] = 1'b1; data_s[1] = 8'h32; last_s[1] = 1'b1;
        step();
        valid_s[1] = 1'b0;
        step();
        valid_s[3] = 1'b0;
        repeat (2) step();
        exp_l = '{{2'd1, 8'h31, 1'b0}, {2'd1, 8'h32, 1'b1}, {2'd3, 8'h33, 1'b1}};
        n_checks++;
        if (obs.size() != 3) begin
            n_errors++;
            $display("FAIL stall_count: got %0d beats expected 3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp_l[i]) begin
                    n_errors++;
                    $display("FAIL stall[%0d]: got %h expected %h", i, obs[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        ready_s = 1'b0;
        valid_s = 4'b0101;
        last_s  = 4'b0101;
        data_s[0] = 8'h40;
        data_s[2] = 8'h42;
        step();
        repeat (5) begin
            step();
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== 8'h40 || ready_o !== 4'b0000) begin
                n_errors++;
                $display("FAIL backpressure_hold: got valid=%b data=%h ready=%b expected 1 40 0000",
                         valid_o, data_o, ready_o);
            end
        end
        ready_s = 1'b1;
        step();
        valid_s = 4'b0000;
        repeat (2) step();
        n_checks++;
        if (obs.size() != 2 || obs[0] !== {2'd0, 8'h40, 1'b1} || obs[1] !== {2'd2, 8'h42, 1'b1}) begin
            n_errors++;
            $display("FAIL backpressure_seq: got %0d beats first %h expected 2 beats 081 then 485",
                     obs.size(), (obs.size() > 0) ? obs[0] : 11'h0);
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        valid_s = 4'b0100;
        data_s[2] = 8'h52; last_s[2] = 1'b0;
        step();
        data_s[2] = 8'h53;
        step();
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 4'b0000 || data_o !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset: got valid=%b ready=%b data=%h expected 0 0000 00", valid_o, ready_o, data_o);
        end
        step();
        rst = 1'b0;
        obs.delete();
        valid_s = 4'b0110;
        data_s[1] = 8'h61; last_s[1] = 1'b1;
        data_s[2] = 8'h62; last_s[2] = 1'b1;
        #1;
        n_checks++;
        if (ready_o !== 4'b0010) begin
            n_errors++;
            $display("FAIL post_reset_grant: got %b expected 0010", ready_o);
        end
        step();
        valid_s[1] = 1'b0;
        step();
        valid_s[2] = 1'b0;
        repeat (2) step();
        n_checks++;
        if (obs.size() < 2 || obs[0] !== {2'd1, 8'h61, 1'b1} || obs[1] !== {2'd2, 8'h62, 1'b1}) begin
            n_errors++;
            $display("FAIL post_reset_seq: got %0d beats first %h expected 2c3 then 4c5",
                     obs.size(), (obs.size() > 0) ? obs[0] : 11'h0);
        end
    endtask

    task automatic test_random();
        logic [5:0] seq [0:N-1];
        int wait_pkts [0:N-1];
        apply_reset();
        for (int i = 0; i < N; i++) begin
            seq[i]       = 6'd0;
            wait_pkts[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                valid_s[i] = valid_s[i] ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
                last_s[i]  = ($urandom_range(0, 2) == 0);
                data_s[i]  = {2'(i), seq[i]};
            end
            ready_s = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (!valid_s[i] || (m_xfer && m_xfer_id == i)) begin
                    wait_pkts[i] = 0;
                end else if (m_xfer && m_xfer_last) begin
                    wait_pkts[i]++;
                    n_checks++;
                    if (wait_pkts[i] > N - 1) begin
                        n_errors++;
                        $display("FAIL starvation: requester %0d waited %0d packets, limit %0d", i, wait_pkts[i], N - 1);
                    end
                end
            end
            if (m_xfer) seq[m_xfer_id] = seq[m_xfer_id] + 6'd1;
        end
        valid_s = 4'b0000;
        ready_s = 1'b1;
        repeat (3) step();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL random_drain: got %0d beats left expected 0", sb.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_s = 4'b0000;
        last_s  = 4'b0000;
        data_s  = '0;
        ready_s = 1'b1;
        test_reset();
        test_single_beat();
        test_locked_packet();
        test_owner_stall();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 4, meaning the number of requester streams (range 1..16).
REQ-002 The block SHALL have parameter DataWidth, default 8, meaning the payload width per beat.
REQ-003 The block SHALL have localparam IdWidth = max(1, clog2(NumReq)), meaning the width of the requester index.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port data_i, input, NumReq x DataWidth, the payload of each requester.
REQ-007 The block SHALL have port valid_i, input, NumReq, per-requester beat valid.
REQ-008 The block SHALL have port last_i, input, NumReq, per-requester end-of-packet flag.
REQ-009 The block SHALL have port ready_o, output, NumReq, per-requester beat accept.
REQ-010 The block SHALL have port valid_o, output, 1, output beat valid.
REQ-011 The block SHALL have port data_o, output, DataWidth, output payload.
REQ-012 The block SHALL have port last_o, output, 1, output end-of-packet flag.
REQ-013 The block SHALL have port id_o, output, IdWidth, index of the requester that sourced the beat.
REQ-014 The block SHALL have port ready_i, input, 1, downstream accept.

Function
REQ-015 A beat SHALL transfer on any input i when valid_i[i] and ready_o[i] are both high at a rising edge; output transfer is valid_o and ready_i both high.
REQ-016 The block SHALL register output beats in one single-entry output stage: latency 1 cycle from input transfer to valid_o; the stage SHALL be able to accept a new beat whenever it is empty or ready_i is high, giving 1 beat/cycle throughput.
REQ-017 The controller SHALL have states IDLE (no packet in progress) and LOCKED (packet owned by requester owner_q).
REQ-018 In IDLE, the grant SHALL be the first requester with valid_i high, searching upward from ptr_q with wrap-around from NumReq-1 to 0; the grant is combinational and unregistered.
REQ-019 ready_o[i] SHALL be high only when i is the current grant and the output stage can accept; at most one ready_o bit SHALL be high per cycle.
REQ-020 An IDLE transfer with last_i=1 (single-beat packet) SHALL keep the state IDLE and set ptr_q to granted index+1 (mod NumReq).
REQ-021 An IDLE transfer with last_i=0 SHALL move to LOCKED with owner_q set to the granted index.
REQ-022 In LOCKED, the grant SHALL be owner_q regardless of other valids; if the owner drops valid_i, the grant SHALL be held and no other requester accepted.
REQ-023 A LOCKED transfer with last_i=1 SHALL return to IDLE and set ptr_q to owner_q+1 (mod NumReq); the next arbitration occurs in the following cycle.
REQ-024 The output stage SHALL capture data, last and grant index together on every input transfer and only then.
REQ-025 When the output stage is full and ready_i is low, all ready_o SHALL be low and the stage contents SHALL stay stable.
REQ-026 With no valid_i high in IDLE, ready_o SHALL be all zero and ptr_q SHALL be unchanged.
REQ-027 With NumReq=1, the block SHALL behave as a single elastic stage with id_o constant 0.

Reset
REQ-028 On reset_i asserted, asynchronously: state IDLE, ptr_q 0, owner_q 0, valid_o 0, data_o 0, last_o 0, id_o 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from requester 0 with no residual lock.
REQ-030 ready_o SHALL be all zero while reset_i is high.

Structure
REQ-031 Package arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the IdWidth computation function.
REQ-032 The output stage SHALL be one sub-module, arb_out_stage: a single-entry elastic register with asynchronous reset and width DataWidth+1+IdWidth.
REQ-033 Arbitration, pointer and lock logic SHALL live in rr_stream_arbiter itself.

Verification
REQ-034 All four requesters hold single-beat packets, ready_i=1 -> id_o sequence 0,1,2,3,0, one beat per cycle, first valid_o one cycle after first accept.
REQ-035 Requester 1 sends 3-beat packet (data 0x11,0x12,0x13, last on third) while requester 2 is valid -> output 0x11,0x12,0x13 with id_o=1, then requester 2.
REQ-036 Requester 1 drops valid for 2 cycles mid-packet while requester 3 valid -> ready_o[3] stays 0; the packet completes after requester 1 resumes.
REQ-037 ready_i=0 for 5 cycles with stage full -> valid_o, data_o stable, ready_o all 0; on ready_i=1 transfer resumes with no lost or duplicated beat.
REQ-038 Reset asserted during LOCKED on owner 2 -> valid_o 0 immediately; after release with requesters 1 and 2 valid, the first grant is requester 1.
REQ-039 Random valid/last/ready_i traffic, 10k cycles -> per-requester ordering preserved, packets never interleaved, no requester starved beyond NumReq-1 packets.
